line_fill_mem: RTL
==================

Name: line_fill_mem

Overview:
- Memory-side responder for data_cache line fills and writebacks: accepts one line request, waits a programmable latency, then streams or absorbs a LINE_WORDS-beat burst.
- Sits below data_cache and replaces its flat internal RAM in the memory hierarchy.
- Backing storage is array mem_r, loadable by $readmemh from benches.

Parameters:
- ADDR_W, 64, request byte-address width.
- DATA_W, 64, beat width in bits (one word per beat).
- LINE_WORDS, 4, beats per line; power of two, >=2.
- MEM_WORDS, 1024, storage depth in words; power of two.
- LATENCY, 4, cycles spent in WAIT between request accept and first data beat; 0 allowed.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  line request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_we_i  in  1  1 = writeback (write burst), 0 = fill (read burst).
- req_addr_i  in  ADDR_W  byte address of any byte in the line.
- wdata_valid_i  in  1  write beat valid.
- wdata_ready_o  out  1  write beat accepted.
- wdata_i  in  DATA_W  write beat data.
- rdata_valid_o  out  1  read beat valid.
- rdata_ready_i  in  1  read beat accepted.
- rdata_o  out  DATA_W  read beat data.
- rdata_last_o  out  1  final beat of the fill.
- wr_done_o  out  1  one-cycle pulse once a writeback has fully committed.

Behaviour:
- Reset (async assert, sync deassert expected): FSM goes to IDLE. req_ready_o=1 only once out of reset. All other outputs are 0. Beat and latency counters clear. mem_r is NOT cleared.
- Word index is req_addr_i[log2(MEM_WORDS)+2:3]; the low log2(LINE_WORDS) bits of it are forced to 0 (line base). Higher address bits are ignored, so addresses wrap modulo MEM_WORDS.
- States: IDLE, WAIT, RD_BURST, WR_BURST, WR_RESP.
- IDLE:
  - req_ready_o=1.
  - On handshake, latch base and we, load lat_cnt=LATENCY.
  - Next state is WAIT if LATENCY>0. Otherwise go directly to the burst state.
- WAIT:
  - req_ready_o=0, wdata_ready_o=0, rdata_valid_o=0.
  - Decrement lat_cnt each cycle. Leave WAIT after exactly LATENCY cycles, to RD_BURST if we=0, else WR_BURST.
- RD_BURST:
  - rdata_o is registered. It is loaded with mem_r[base+0] on entry and with mem_r[base+beat+1] on each accepted non-last beat.
  - rdata_valid_o=1 throughout. rdata_o and rdata_last_o hold stable while rdata_ready_i=0.
  - rdata_last_o=1 when beat==LINE_WORDS-1. The handshake on the last beat returns to IDLE, with valid deasserted the next cycle.
  - First beat is visible LATENCY+1 cycles after the request-accept edge.
- WR_BURST:
  - wdata_ready_o=1. Each handshake writes wdata_i to mem_r[base+beat] and increments beat.
  - The handshake on the last beat moves to WR_RESP.
  - Beats presented early (during WAIT) are not accepted. The sender must hold them.
- WR_RESP: wr_done_o=1 for exactly one cycle, then IDLE. The written line is readable by any subsequent fill.
- Beat counter is log2(LINE_WORDS) bits and wraps; base+beat is an OR, never a carry across the line.
- Only one outstanding request. No new request is accepted until IDLE; req_ready_o=0 in every non-IDLE state.
- Reset asserted mid-burst: abandon the transaction immediately. Write beats already accepted stay in mem_r; no wr_done_o is issued.

Decomposition:
- Shared package mem_pkg holds:
  - enum mem_state_e {IDLE, WAIT, RD_BURST, WR_BURST, WR_RESP};
  - localparams for word-offset and line-offset widths;
  - typedef line_idx_t for the beat counter.
- Natural sub-module: line_fill_mem_fsm, holding state, latency counter and beat counter, and emitting handshake enables. The top holds mem_r and the rdata register.

Test Plan:
- Preload mem_r[8..11]=0x10,0x11,0x12,0x13, LATENCY=4. Fill at req_addr_i=0x48 -> beats 0x10,0x11,0x12,0x13 from base word 8. First valid 5 cycles after accept. rdata_last_o only on 0x13.
- Same fill with rdata_ready_i low for 3 cycles on beat 2 -> rdata_o holds 0x12 and valid stays high. No beat is skipped or duplicated.
- Writeback to 0x100 with data 0xA0..0xA3, then a fill at 0x118 -> wr_done_o pulses once, and the fill returns 0xA0..0xA3.
- req_addr_i=0x2040 with MEM_WORDS=1024 -> wraps to word 8 and returns 0x10..0x13. req_ready_o stays 0 during the burst even with a second req_valid_i held high.
- LATENCY=0 fill -> first beat valid the cycle after accept.
- Assert rst_ni low after 2 of 4 write beats -> all outputs 0 immediately and no wr_done_o. The 2 written words persist and the other 2 are unchanged.

Source files
------------

// File: rtl/line_fill_mem_pkg.sv
// Shared types and widths for the line-fill memory responder.
// Widths here match the default line length and depth of line_fill_mem.
package mem_pkg;

    localparam int LINE_WORDS_P = 4;
    localparam int MEM_WORDS_P  = 1024;
    localparam int BYTE_OFF_W   = 3;
    localparam int WORD_IDX_W   = $clog2(MEM_WORDS_P);
    localparam int LINE_OFF_W   = $clog2(LINE_WORDS_P);

    typedef logic [LINE_OFF_W-1:0] line_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_BURST,
        WR_BURST,
        WR_RESP
    } mem_state_e;

endpackage

// File: rtl/line_fill_mem_if.sv
// Request / write-beat / read-beat bundle between data_cache and the line-fill memory.
interface line_fill_mem_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              wdata_valid_i;
    logic              wdata_ready_o;
    logic [DATA_W-1:0] wdata_i;
    logic              rdata_valid_o;
    logic              rdata_ready_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_last_o;
    logic              wr_done_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, wdata_valid_i, wdata_i, rdata_ready_i,
        output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o, wr_done_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, wdata_valid_i, wdata_i, rdata_ready_i,
        input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o, wr_done_o
    );
endinterface

// File: rtl/line_fill_mem_fsm.sv
// Sequencer for one line transaction: latency countdown, beat counting and handshake enables.
//
//   state    | meaning
//   IDLE     | ready for a new line request
//   WAIT     | counting down the access latency
//   RD_BURST | streaming fill beats out of the rdata register
//   WR_BURST | absorbing writeback beats into storage
//   WR_RESP  | one-cycle completion pulse for a writeback
module line_fill_mem_fsm
    import mem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int LINE_WORDS = LINE_WORDS_P,
    parameter int LINE_N_W   = WORD_IDX_W - LINE_OFF_W
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    input  logic                           req_we_i,
    input  logic [LINE_N_W-1:0]            req_line_i,
    input  logic                           wdata_valid_i,
    input  logic                           rdata_ready_i,
    output logic                           req_ready_o,
    output logic                           wdata_ready_o,
    output logic                           rdata_valid_o,
    output logic                           rdata_last_o,
    output logic                           wr_done_o,
    output logic                           mem_we_o,
    output logic                           rd_load_o,
    output logic [LINE_N_W+LINE_OFF_W-1:0] mem_addr_o
);

    localparam int LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam line_idx_t LAST_BEAT = line_idx_t'(LINE_WORDS - 1);

    mem_state_e          state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    line_idx_t           beat_q, beat_d;
    logic [LINE_N_W-1:0] line_q, line_d;
    logic                we_q, we_d;
    logic                rdy_q, rdy_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        beat_d        = beat_q;
        line_d        = line_q;
        we_d          = we_q;
        rdy_d         = 1'b1;
        req_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_last_o  = 1'b0;
        wr_done_o     = 1'b0;
        mem_we_o      = 1'b0;
        rd_load_o     = 1'b0;
        mem_addr_o    = {line_q, beat_q};

        case (state_q)
            IDLE: begin
                // rdy_q keeps the request port closed until the first edge after reset
                req_ready_o = rdy_q;
                if (req_valid_i && rdy_q) begin
                    line_d = req_line_i;
                    we_d   = req_we_i;
                    lat_d  = LAT_W'(LATENCY);
                    beat_d = '0;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                    end else if (req_we_i) begin
                        state_d = WR_BURST;
                    end else begin
                        state_d    = RD_BURST;
                        rd_load_o  = 1'b1;
                        mem_addr_o = {req_line_i, line_idx_t'(0)};
                    end
                end
            end
            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    if (we_q) begin
                        state_d = WR_BURST;
                    end else begin
                        state_d   = RD_BURST;
                        rd_load_o = 1'b1;
                    end
                end
            end
            RD_BURST: begin
                rdata_valid_o = 1'b1;
                rdata_last_o  = (beat_q == LAST_BEAT);
                if (rdata_ready_i) begin
                    beat_d = beat_q + line_idx_t'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        rd_load_o  = 1'b1;
                        mem_addr_o = {line_q, beat_q + line_idx_t'(1)};
                    end
                end
            end
            WR_BURST: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    mem_we_o = 1'b1;
                    beat_d   = beat_q + line_idx_t'(1);
                    if (beat_q == LAST_BEAT) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                wr_done_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/line_fill_mem.sv
// Memory-side responder for data_cache line fills and writebacks.
// Holds the word storage and the registered read-beat data; sequencing lives in line_fill_mem_fsm.
module line_fill_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = LINE_WORDS_P,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    line_fill_mem_if.slave  bus
);

    localparam int WIDX_W   = $clog2(MEM_WORDS);
    localparam int LINE_N_W = WIDX_W - LINE_OFF_W;

    logic [DATA_W-1:0]   mem_r [MEM_WORDS];
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;
    logic                rd_load;
    logic [WIDX_W-1:0]   mem_addr;
    logic [LINE_N_W-1:0] req_line;
    logic                unused_addr;

    // Line number only: word-in-line bits are dropped and high bits wrap modulo MEM_WORDS
    assign req_line    = bus.req_addr_i[WIDX_W+BYTE_OFF_W-1 : LINE_OFF_W+BYTE_OFF_W];
    assign unused_addr = ^{bus.req_addr_i[ADDR_W-1:WIDX_W+BYTE_OFF_W],
                           bus.req_addr_i[LINE_OFF_W+BYTE_OFF_W-1:0]};

    line_fill_mem_fsm #(
        .LATENCY    (LATENCY),
        .LINE_WORDS (LINE_WORDS),
        .LINE_N_W   (LINE_N_W)
    ) u_fsm (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (bus.req_valid_i),
        .req_we_i      (bus.req_we_i),
        .req_line_i    (req_line),
        .wdata_valid_i (bus.wdata_valid_i),
        .rdata_ready_i (bus.rdata_ready_i),
        .req_ready_o   (bus.req_ready_o),
        .wdata_ready_o (bus.wdata_ready_o),
        .rdata_valid_o (bus.rdata_valid_o),
        .rdata_last_o  (bus.rdata_last_o),
        .wr_done_o     (bus.wr_done_o),
        .mem_we_o      (mem_we),
        .rd_load_o     (rd_load),
        .mem_addr_o    (mem_addr)
    );

    // Storage is deliberately left out of reset so contents survive an aborted transaction
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_r[mem_addr] <= bus.wdata_i;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_load) rdata_d = mem_r[mem_addr];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign bus.rdata_o = rdata_q;

endmodule
